// File: rtl/lc3_mem_sequencer.sv
// LC3 memory-access stage sequencer: runs one load/store/indirect operation at a time
// over a request/acknowledge data-memory port and hands load results to writeback.
module lc3_mem_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              Data_req,
   output logic              Data_rd,
   output logic [ADDR_W-1:0] Data_addr,
   output logic [DATA_W-1:0] Data_din,
   input  logic              Data_ack,
   input  logic [DATA_W-1:0] Data_dout,
   output logic [DATA_W-1:0] memout,
   output logic              memout_valid,
   output logic [1:0]        mem_state
);

   typedef enum logic [1:0] {
      ST_READ     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_INDIRECT = 2'd2,
      ST_IDLE     = 2'd3
   } state_t;

   state_t state_r;
   logic   ind_store_r;

   function automatic state_t entry_state(input logic [1:0] op);
      case (op)
         2'b00:   entry_state = ST_READ;
         2'b01:   entry_state = ST_WRITE;
         default: entry_state = ST_INDIRECT;
      endcase
   endfunction

   assign mem_state = state_r;

   // Sequencer FSM; every port output is a register updated alongside the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         ind_store_r  <= 1'b0;
         req_ready    <= 1'b1;
         Data_req     <= 1'b0;
         Data_rd      <= 1'b1;
         Data_addr    <= {ADDR_W{1'b0}};
         Data_din     <= {DATA_W{1'b0}};
         memout       <= {DATA_W{1'b0}};
         memout_valid <= 1'b0;
      end else begin
         memout_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  state_r     <= entry_state(req_op);
                  ind_store_r <= req_op[0];
                  req_ready   <= 1'b0;
                  Data_req    <= 1'b1;
                  Data_rd     <= (req_op != 2'b01);
                  Data_addr   <= req_addr;
                  if (req_op[0]) begin
                     Data_din <= req_wdata;
                  end else begin
                     Data_din <= Data_din;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_INDIRECT: begin
               // The pointer word becomes the address of the final access.
               if (Data_ack) begin
                  Data_addr <= ADDR_W'(Data_dout);
                  if (ind_store_r) begin
                     state_r <= ST_WRITE;
                     Data_rd <= 1'b0;
                  end else begin
                     state_r <= ST_READ;
                     Data_rd <= 1'b1;
                  end
               end else begin
                  state_r <= ST_INDIRECT;
               end
            end
            ST_READ: begin
               if (Data_ack) begin
                  memout       <= Data_dout;
                  memout_valid <= 1'b1;
                  state_r      <= ST_IDLE;
                  Data_req     <= 1'b0;
                  req_ready    <= 1'b1;
               end else begin
                  state_r <= ST_READ;
               end
            end
            ST_WRITE: begin
               if (Data_ack) begin
                  state_r   <= ST_IDLE;
                  Data_req  <= 1'b0;
                  Data_rd   <= 1'b1;
                  req_ready <= 1'b1;
               end else begin
                  state_r <= ST_WRITE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               Data_req  <= 1'b0;
               Data_rd   <= 1'b1;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Self-checking bench for lc3_mem_sequencer: vector table of operations plus hand sequences,
// a waiting-state memory model and a scoreboard of expected load results.
module tb_lc3_mem_sequencer;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        Data_req;
   logic        Data_rd;
   logic [15:0] Data_addr;
   logic [15:0] Data_din;
   logic        Data_ack;
   logic [15:0] Data_dout;
   logic [15:0] memout;
   logic        memout_valid;
   logic [1:0]  mem_state;

   lc3_mem_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready),
      .Data_req(Data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
      .Data_ack(Data_ack), .Data_dout(Data_dout),
      .memout(memout), .memout_valid(memout_valid), .mem_state(mem_state)
   );

   typedef struct {
      logic [1:0]  op;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] ptr;
      logic [15:0] data;
      int          waits;
   } vec_t;

   typedef struct packed {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
   } acc_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          waits = 0;
   int          pulses = 0;
   int          req_cycles = 0;
   logic [1:0]  last_state = 2'd3;
   logic [15:0] last_load = 16'h0000;
   logic [15:0] mem [logic [15:0]];
   acc_t        acc_q [$];
   logic [1:0]  st_q [$];
   logic [15:0] exp_q [$];
   vec_t        vecs [6];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory model: acks after 'waits' wait cycles, logs completed accesses, checks port stability.
   initial begin : mem_model
      bit          done;
      bit          active;
      int          wcnt;
      acc_t        cur;
      acc_t        smp;
      Data_ack  = 1'b0;
      Data_dout = 16'h0000;
      active    = 1'b0;
      wcnt      = 0;
      forever begin
         @(posedge clock);
         done = Data_req && Data_ack && !reset;
         smp  = acc_t'{rd: Data_rd, addr: Data_addr, din: Data_din};
         #1;
         if (done) begin
            acc_q.push_back(smp);
            if (!smp.rd) mem[smp.addr] = smp.din;
            active   = 1'b0;
            Data_ack = 1'b0;
         end
         if (!reset && Data_req) begin
            if (!active) begin
               active = 1'b1;
               wcnt   = 0;
               cur    = acc_t'{rd: Data_rd, addr: Data_addr, din: Data_din};
            end else begin
               check("stable_rd", Data_rd, cur.rd);
               check("stable_addr", Data_addr, cur.addr);
               if (!cur.rd) check("stable_din", Data_din, cur.din);
            end
            if (wcnt == waits) begin
               Data_ack = 1'b1;
               if (Data_rd) Data_dout = mem[Data_addr];
            end else begin
               wcnt++;
            end
         end else begin
            active   = 1'b0;
            Data_ack = 1'b0;
         end
      end
   end

   // Output monitor: state trace, strobe cycles, and scoreboard pop on each load result.
   always @(negedge clock) begin
      if (Data_req) req_cycles++;
      if (mem_state != last_state) begin
         st_q.push_back(mem_state);
         last_state = mem_state;
      end
      if (memout_valid) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check("spurious_memout_valid", memout_valid, 1'b0);
         end else begin
            check("memout", memout, exp_q.pop_front());
            check("ready_with_valid", req_ready, 1'b1);
         end
      end
   end

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (mem_state == 2'd3) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check({tag, "_idle_timeout"}, mem_state, 2'd3);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          n;
      int          p0;
      logic        exp_rd [2];
      logic [15:0] exp_addr [2];
      logic [1:0]  exp_st [2];
      logic [15:0] tgt;
      mem.delete();
      if (v.op[1]) begin
         mem[v.addr] = v.ptr;
         tgt = v.ptr;
         n = 2;
         exp_rd[0] = 1'b1;  exp_addr[0] = v.addr; exp_st[0] = 2'd2;
         exp_rd[1] = !v.op[0]; exp_addr[1] = v.ptr; exp_st[1] = v.op[0] ? 2'd1 : 2'd0;
      end else begin
         tgt = v.addr;
         n = 1;
         exp_rd[0] = !v.op[0]; exp_addr[0] = v.addr; exp_st[0] = v.op[0] ? 2'd1 : 2'd0;
      end
      if (!v.op[0]) begin
         mem[tgt] = v.data;
         exp_q.push_back(v.data);
      end
      waits = v.waits;
      acc_q.delete();
      st_q.delete();
      req_cycles = 0;
      p0 = pulses;
      check({tag, "_ready_before"}, req_ready, 1'b1);
      @(negedge clock);
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      wait_idle(tag);
      #1;
      check({tag, "_acc_count"}, acc_q.size(), n);
      for (int k = 0; k < n && k < acc_q.size(); k++) begin
         check($sformatf("%s_acc%0d_rd", tag, k), acc_q[k].rd, exp_rd[k]);
         check($sformatf("%s_acc%0d_addr", tag, k), acc_q[k].addr, exp_addr[k]);
         if (!exp_rd[k]) check($sformatf("%s_acc%0d_din", tag, k), acc_q[k].din, v.wdata);
      end
      check({tag, "_state_count"}, st_q.size(), n + 1);
      for (int k = 0; k < n && k < st_q.size(); k++)
         check($sformatf("%s_state%0d", tag, k), st_q[k], exp_st[k]);
      if (st_q.size() > n) check({tag, "_state_end"}, st_q[n], 2'd3);
      check({tag, "_req_cycles"}, req_cycles, n * (v.waits + 1));
      check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
      if (v.op[0]) begin
         check({tag, "_no_pulse"}, pulses - p0, 0);
         check({tag, "_memout_held"}, memout, last_load);
         check({tag, "_mem_written"}, mem[tgt], v.wdata);
      end else begin
         check({tag, "_one_pulse"}, pulses - p0, 1);
         last_load = v.data;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "global timeout");
   end

   initial begin
      int p0;
      bit seen;
      vecs[0] = '{2'b00, 16'h3000, 16'h0000, 16'h0000, 16'h1234, 0};
      vecs[1] = '{2'b01, 16'h4010, 16'hBEEF, 16'h0000, 16'h0000, 3};
      vecs[2] = '{2'b10, 16'h3100, 16'h0000, 16'h5000, 16'h00AA, 0};
      vecs[3] = '{2'b11, 16'h3200, 16'h7777, 16'h6001, 16'h0000, 0};
      vecs[4] = '{2'b00, 16'hFFFF, 16'h0000, 16'h0000, 16'h8001, 2};
      vecs[5] = '{2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'h5A5A, 1};

      reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0000; req_wdata = 16'h0000;
      repeat (3) @(negedge clock);
      check("rst_mem_state", mem_state, 2'd3);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_Data_req", Data_req, 1'b0);
      check("rst_Data_rd", Data_rd, 1'b1);
      check("rst_Data_addr", Data_addr, 16'h0000);
      check("rst_Data_din", Data_din, 16'h0000);
      check("rst_memout", memout, 16'h0000);
      check("rst_memout_valid", memout_valid, 1'b0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Ack while idle must be ignored.
      p0 = pulses;
      @(negedge clock);
      Data_ack = 1'b1;
      @(posedge clock);
      #1;
      check("idle_ack_state", mem_state, 2'd3);
      check("idle_ack_req", Data_req, 1'b0);
      @(negedge clock);
      check("idle_ack_no_pulse", pulses - p0, 0);

      // req_valid held through a waiting load with a different address: accepted on first IDLE edge.
      mem.delete();
      mem[16'h3300] = 16'h1111;
      mem[16'h3400] = 16'h2222;
      waits = 2;
      p0 = pulses;
      acc_q.delete();
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      @(negedge clock);
      req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h3300;
      @(posedge clock);
      #1;
      req_addr = 16'h3400;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (memout_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("b2b_first_pulse", seen, 1'b1);
      check("b2b_ready_with_pulse", req_ready, 1'b1);
      @(posedge clock);
      #1;
      check("b2b_second_accept_state", mem_state, 2'd0);
      check("b2b_second_addr", Data_addr, 16'h3400);
      req_valid = 1'b0;
      wait_idle("b2b");
      #1;
      check("b2b_pulses", pulses - p0, 2);
      check("b2b_acc_count", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         check("b2b_acc0_addr", acc_q[0].addr, 16'h3300);
         check("b2b_acc1_addr", acc_q[1].addr, 16'h3400);
      end
      check("b2b_scoreboard_empty", exp_q.size(), 0);
      last_load = 16'h2222;

      // Reset asserted while the indirect pointer read is waiting.
      mem.delete();
      mem[16'h3100] = 16'h5000;
      mem[16'h5000] = 16'h00AA;
      waits = 6;
      p0 = pulses;
      @(negedge clock);
      req_valid = 1'b1; req_op = 2'b10; req_addr = 16'h3100;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      check("rstmid_in_indirect", mem_state, 2'd2);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_Data_req", Data_req, 1'b0);
      check("rstmid_mem_state", mem_state, 2'd3);
      check("rstmid_memout", memout, 16'h0000);
      check("rstmid_req_ready", req_ready, 1'b1);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rstmid_no_pulse", pulses - p0, 0);
      check("rstmid_memout_held", memout, 16'h0000);
      last_load = 16'h0000;
      run_vec('{2'b00, 16'h3000, 16'h0000, 16'h0000, 16'hC0DE, 1}, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
